switch_debouncer: RTL and testbench

Input-conditioning stage that sits between the board slide switches and the processor's memory-mapped switch input. Each raw switch bit is brought into the `clk` domain through a two-flop synchronizer and debounced with a per-bit stability counter. The block drives the clean switch vector straight into the memory/peripheral block, so software reads only glitch-free values. It also produces per-bit edge pulses and, optionally, a sticky event register.

---
 rtl/switch_debouncer.sv | 67 ++++++
 tb/tb_switch_debouncer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchronizer plus per-bit stability debouncer for slide switches
// Optional sticky event register (evt_q/evt_clr) is built when SWDEB_EVENT_EN is defined.
module switch_debouncer #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
`ifdef SWDEB_EVENT_EN
  ,
  output logic [WIDTH-1:0] evt_q,
  input  logic [WIDTH-1:0] evt_clr
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1       <= '0;
      s2       <= '0;
      sw_clean <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
      for (int i = 0; i < WIDTH; i++) begin
        sw_rise[i] <= 1'b0;
        sw_fall[i] <= 1'b0;
        // Any cycle agreeing with the accepted level restarts the stability window.
        if (s2[i] == sw_clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]      <= '0;
          sw_clean[i] <= s2[i];
          sw_rise[i]  <= s2[i];
          sw_fall[i]  <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign changed = |(sw_rise | sw_fall);

`ifdef SWDEB_EVENT_EN
  // Set wins over a coincident clear so no accepted change is ever lost.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) evt_q <= '0;
    else         evt_q <= (evt_q & ~evt_clr) | sw_rise | sw_fall;
  end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - scoreboard bench for switch_debouncer (WIDTH=10, DEBOUNCE_CYCLES=4)
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       nreset;
  logic [9:0] sw_raw;
  logic [9:0] sw_clean, sw_rise, sw_fall;
  logic       changed;
`ifdef SWDEB_EVENT_EN
  logic [9:0] evt_q;
  logic [9:0] evt_clr;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         at_edge;
    logic [9:0] clean;
    logic [9:0] rise;
    logic [9:0] fall;
  } exp_t;
  exp_t sb[$];

  switch_debouncer #(.WIDTH(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .changed  (changed)
`ifdef SWDEB_EVENT_EN
    ,
    .evt_q    (evt_q),
    .evt_clr  (evt_clr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Acceptance expected n edges after the current negedge.
  task automatic expect_at(input int n, input logic [9:0] c, input logic [9:0] r, input logic [9:0] f);
    exp_t e;
    e.at_edge = cyc + n;
    e.clean   = c;
    e.rise    = r;
    e.fall    = f;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (changed === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {12'h0, sw_rise, sw_fall}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_edge", cyc, e.at_edge);
        check("pulse_clean", sw_clean, e.clean);
        check("pulse_rise", sw_rise, e.rise);
        check("pulse_fall", sw_fall, e.fall);
      end
    end
  end

  initial begin
    nreset = 1'b0;
    sw_raw = 10'h3FF;
`ifdef SWDEB_EVENT_EN
    evt_clr = '0;
`endif
    step(3);
    check("rst_clean", sw_clean, 0);
    check("rst_rise", sw_rise, 0);
    check("rst_fall", sw_fall, 0);
    check("rst_changed", changed, 0);
`ifdef SWDEB_EVENT_EN
    check("rst_evt", evt_q, 0);
`endif

    // Reset release with switches already high.
    nreset = 1'b1;
    expect_at(6, 10'h3FF, 10'h3FF, 10'h000);
    step(5);
    check("rel_not_yet", sw_clean, 0);
    step(1);
    step(1);
    check("rel_pulse_one_cycle", sw_rise, 0);
    check("rel_clean_hold", sw_clean, 10'h3FF);

    // All fall, then a clean single-bit step.
    sw_raw = 10'h000;
    expect_at(6, 10'h000, 10'h000, 10'h3FF);
    step(8);
    sw_raw = 10'h008;
    expect_at(6, 10'h008, 10'h008, 10'h000);
    step(8);
    check("step_clean", sw_clean, 10'h008);

    // Bounce on bit 0: 1,0,1,0 then hold 1.
    sw_raw = 10'h009; step(1);
    sw_raw = 10'h008; step(1);
    sw_raw = 10'h009; step(1);
    sw_raw = 10'h008; step(1);
    sw_raw = 10'h009;
    expect_at(6, 10'h009, 10'h001, 10'h000);
    step(5);
    check("bounce_not_yet", sw_clean, 10'h008);
    step(3);

    // Simultaneous rise and fall on many bits.
    sw_raw = 10'h0F0;
    expect_at(6, 10'h0F0, 10'h0F0, 10'h009);
    step(8);
    sw_raw = 10'h00F;
    expect_at(6, 10'h00F, 10'h00F, 10'h0F0);
    step(8);

    // Reset two cycles into a count on bit 9.
    sw_raw = 10'h20F;
    step(4);
    nreset = 1'b0;
    step(1);
    check("midrst_clean", sw_clean, 0);
    check("midrst_changed", changed, 0);
    step(1);
    nreset = 1'b1;
    expect_at(6, 10'h20F, 10'h20F, 10'h000);
    step(5);
    check("midrst_not_yet", sw_clean, 0);
    step(3);

`ifdef SWDEB_EVENT_EN
    evt_clr = 10'h3FF;
    step(1);
    evt_clr = 10'h000;
    check("evt_clr_all", evt_q, 0);
    sw_raw = 10'h22F;
    expect_at(6, 10'h22F, 10'h020, 10'h000);
    step(6);
    check("evt_before_set", evt_q, 0);
    step(1);
    check("evt_set", evt_q, 10'h020);
    step(3);
    check("evt_sticky", evt_q, 10'h020);
    evt_clr = 10'h020;
    step(1);
    evt_clr = 10'h000;
    check("evt_cleared", evt_q, 0);
    sw_raw = 10'h20F;
    expect_at(6, 10'h20F, 10'h000, 10'h020);
    step(6);
    evt_clr = 10'h020;
    step(1);
    evt_clr = 10'h000;
    check("evt_set_beats_clr", evt_q, 10'h020);
    step(1);
    check("evt_hold_after", evt_q, 10'h020);
`endif

    step(10);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
